// File: rtl/cdb_broadcast_arbiter.sv
// cdb_broadcast_arbiter: per-source result FIFOs merged round-robin onto one registered CDB; define CDB_FLUSH_EN to enable i_flush
module cdb_broadcast_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int TAG_W = 4,
  parameter int DATA_W = 32,
  parameter int RSNUM_W = 3,
  parameter int FIFO_DEPTH = 2,
  parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         i_src_valid,
  output logic [NUM_SRC-1:0]         o_src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]   i_src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]  i_src_data,
  input  logic [NUM_SRC*RSNUM_W-1:0] i_src_rsnum,
  output logic [NUM_SRC-1:0]         o_src_finish,
  output logic                       o_cdb_valid,
  output logic [TAG_W-1:0]           o_cdb_tag,
  output logic [DATA_W-1:0]          o_cdb_data,
  output logic [$clog2(NUM_SRC)-1:0] o_cdb_src,
  output logic [RSNUM_W-1:0]         o_cdb_rsnum,
  input  logic                       i_flush
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_SRC);
  logic [TAG_W-1:0]   r_tag   [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0]  r_data  [NUM_SRC][FIFO_DEPTH];
  logic [RSNUM_W-1:0] r_rsnum [NUM_SRC][FIFO_DEPTH];
  logic [PW:0]        r_wp    [NUM_SRC];
  logic [PW:0]        r_rp    [NUM_SRC];
  logic [SW-1:0]      r_rr;
  logic [NUM_SRC-1:0] w_empty, w_full, w_push;
  logic               w_gnt, w_flush;
  logic [SW-1:0]      w_win;
  logic [PW-1:0]      w_rd;
`ifdef CDB_FLUSH_EN
  assign w_flush = i_flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = i_flush;
  assign w_flush = 1'b0;
`endif
  // Full uses the extra pointer MSB to tell a wrapped writer from an empty FIFO
  genvar c;
  for (c = 0; c < NUM_SRC; c++) begin : g_st
    assign w_empty[c] = r_wp[c] == r_rp[c];
    assign w_full[c]  = (r_wp[c][PW] != r_rp[c][PW]) && (r_wp[c][PW-1:0] == r_rp[c][PW-1:0]);
    assign w_push[c]  = i_src_valid[c] && !w_full[c] && !w_flush;
  end
  assign o_src_ready = ~w_full;
  assign w_rd = r_rp[w_win][PW-1:0];
  // Round-robin pick: scan from the farthest offset down so the channel nearest r_rr wins
  always_comb begin
    w_gnt = 1'b0;
    w_win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (!w_empty[SW'((int'(r_rr) + k) % NUM_SRC)]) begin
        w_gnt = 1'b1;
        w_win = SW'((int'(r_rr) + k) % NUM_SRC);
      end
  end
  // FIFO storage; pointer updates below decide whether a written slot becomes visible
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_SRC; i++)
      if (w_push[i]) begin
        r_tag[i][r_wp[i][PW-1:0]]   <= i_src_tag[i*TAG_W +: TAG_W];
        r_data[i][r_wp[i][PW-1:0]]  <= i_src_data[i*DATA_W +: DATA_W];
        r_rsnum[i][r_wp[i][PW-1:0]] <= i_src_rsnum[i*RSNUM_W +: RSNUM_W];
      end
  // Pointers, arbiter state and the registered broadcast; flush clears like reset but keeps src/rsnum
  always_ff @(posedge clk)
    if (rst || w_flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
      r_rr         <= '0;
      o_cdb_valid  <= 1'b0;
      o_cdb_tag    <= TAG_FREE;
      o_cdb_data   <= '0;
      o_src_finish <= '0;
      if (rst) begin
        o_cdb_src   <= '0;
        o_cdb_rsnum <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
        if (w_gnt && w_win == SW'(i)) r_rp[i] <= r_rp[i] + 1'b1;
      end
      if (w_gnt) r_rr <= (int'(w_win) == NUM_SRC - 1) ? '0 : w_win + 1'b1;
      o_cdb_valid  <= w_gnt;
      o_cdb_tag    <= w_gnt ? r_tag[w_win][w_rd] : TAG_FREE;
      o_cdb_data   <= w_gnt ? r_data[w_win][w_rd] : '0;
      o_src_finish <= w_gnt ? NUM_SRC'(1) << w_win : '0;
      if (w_gnt) begin
        o_cdb_src   <= w_win;
        o_cdb_rsnum <= r_rsnum[w_win][w_rd];
      end
    end
endmodule
